// File: rtl/adder_arbiter_if.sv
// Bundle of request, shared-adder and response signals for adder_arbiter.
// The slave modport is the arbiter's view; master is the surrounding
// environment (requesters, shared adder and result consumer).
interface adder_arbiter_if #(
  parameter int NREQ        = 4,
  parameter int PIPE_STAGES = 2,
  parameter int EXP_W       = 8,
  parameter int MANT_W      = 16,
  parameter int IDW         = $clog2(NREQ)
);
  localparam int OPW  = EXP_W + MANT_W;
  localparam int SUMW = MANT_W + 1;
  localparam int INFW = $clog2(PIPE_STAGES + 1) + 1;

  // Requester side
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ-1:0][OPW-1:0]  req_in1;
  logic [NREQ-1:0][OPW-1:0]  req_in2;

  // Shared adder side
  logic [OPW-1:0]            add_in1;
  logic [OPW-1:0]            add_in2;
  logic [EXP_W-1:0]          add_sumExp;
  logic [SUMW-1:0]           add_sumMant;

  // Response side
  logic                      resp_valid;
  logic                      resp_ready;
  logic [IDW-1:0]            resp_id;
  logic [EXP_W-1:0]          resp_exp;
  logic [SUMW-1:0]           resp_mant;
  logic [INFW-1:0]           inflight;

  modport slave (
    input  req_valid, req_in1, req_in2, add_sumExp, add_sumMant, resp_ready,
    output req_ready, add_in1, add_in2, resp_valid, resp_id, resp_exp,
           resp_mant, inflight
  );

  modport master (
    output req_valid, req_in1, req_in2, add_sumExp, add_sumMant, resp_ready,
    input  req_ready, add_in1, add_in2, resp_valid, resp_id, resp_exp,
           resp_mant, inflight
  );
endinterface

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin time-sharing of one combinational adder among
// NREQ requesters. The winning requester's operands drive the adder in the
// same cycle; the sum and the requester tag then travel through a
// PIPE_STAGES-deep pipeline that stalls as a whole when the response port
// is blocked.
//
// Operand format: {exponent[EXP_W-1:0], signed mantissa[MANT_W-1:0]}.
// The sum mantissa is one bit wider and is passed through untouched.
module adder_arbiter #(
  parameter int NREQ        = 4,
  parameter int PIPE_STAGES = 2,
  parameter int EXP_W       = 8,
  parameter int MANT_W      = 16,
  parameter int IDW         = $clog2(NREQ)
) (
  input logic             clk,
  input logic             rst_n,
  adder_arbiter_if.slave  bus
);
  localparam int OPW  = EXP_W + MANT_W;
  localparam int SUMW = MANT_W + 1;
  localparam int INFW = $clog2(PIPE_STAGES + 1) + 1;

  // (base + off) mod NREQ for off in 1..NREQ; base is always < NREQ.
  function automatic logic [IDW-1:0] f_wrap(input logic [IDW-1:0] base,
                                            input int off);
    int s;
    s = int'(base) + off;
    return (s >= NREQ) ? IDW'(s - NREQ) : IDW'(s);
  endfunction

  // Number of set stage-valid bits.
  function automatic logic [INFW-1:0] f_popcount(input logic [PIPE_STAGES-1:0] v);
    logic [INFW-1:0] c;
    c = {INFW{1'b0}};
    for (int i = 0; i < PIPE_STAGES; i++) begin
      c = c + INFW'(v[i]);
    end
    return c;
  endfunction

  // Pipeline state
  logic [PIPE_STAGES-1:0] r_v;
  logic [IDW-1:0]         r_id   [PIPE_STAGES];
  logic [EXP_W-1:0]       r_exp  [PIPE_STAGES];
  logic [SUMW-1:0]        r_mant [PIPE_STAGES];

  // Round-robin pointer: last accepted requester
  logic [IDW-1:0]         r_ptr;

  logic                   w_adv;
  logic                   w_gnt_found;
  logic [IDW-1:0]         w_gnt_idx;
  logic                   w_accept;
  logic [NREQ-1:0]        w_req_ready;
  logic [OPW-1:0]         w_add_in1;
  logic [OPW-1:0]         w_add_in2;

  // The whole pipe moves only when the last stage is empty or being drained.
  assign w_adv    = !r_v[PIPE_STAGES-1] || bus.resp_ready;
  assign w_accept = w_gnt_found && w_adv;

  // Round-robin search starting just after the last winner, wrapping once.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = {IDW{1'b0}};
    for (int i = 1; i <= NREQ; i++) begin
      if (!w_gnt_found && bus.req_valid[f_wrap(r_ptr, i)]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = f_wrap(r_ptr, i);
      end else begin
        w_gnt_found = w_gnt_found;
      end
    end
  end

  // Ready goes to the winner only, and only when the pipe can take a value;
  // the winner's operands are steered to the shared adder.
  always_comb begin
    w_req_ready = {NREQ{1'b0}};
    w_add_in1   = {OPW{1'b0}};
    w_add_in2   = {OPW{1'b0}};
    if (w_gnt_found) begin
      w_req_ready[w_gnt_idx] = w_adv;
      w_add_in1              = bus.req_in1[w_gnt_idx];
      w_add_in2              = bus.req_in2[w_gnt_idx];
    end else begin
      w_req_ready = {NREQ{1'b0}};
    end
  end

  // Result pipeline: stage 0 samples the adder on accept, later stages shift;
  // everything holds while the response port is blocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= {PIPE_STAGES{1'b0}};
      for (int k = 0; k < PIPE_STAGES; k++) begin
        r_id[k]   <= {IDW{1'b0}};
        r_exp[k]  <= {EXP_W{1'b0}};
        r_mant[k] <= {SUMW{1'b0}};
      end
    end else if (w_adv) begin
      r_v[0] <= w_accept;
      if (w_accept) begin
        r_id[0]   <= w_gnt_idx;
        r_exp[0]  <= bus.add_sumExp;
        r_mant[0] <= bus.add_sumMant;
      end
      for (int k = 1; k < PIPE_STAGES; k++) begin
        r_v[k]    <= r_v[k-1];
        r_id[k]   <= r_id[k-1];
        r_exp[k]  <= r_exp[k-1];
        r_mant[k] <= r_mant[k-1];
      end
    end
  end

  // Pointer starts at NREQ-1 so requester 0 wins first; moves only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= IDW'(NREQ - 1);
    end else if (w_accept) begin
      r_ptr <= w_gnt_idx;
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.add_in1    = w_add_in1;
  assign bus.add_in2    = w_add_in2;
  assign bus.resp_valid = r_v[PIPE_STAGES-1];
  assign bus.resp_id    = r_id[PIPE_STAGES-1];
  assign bus.resp_exp   = r_exp[PIPE_STAGES-1];
  assign bus.resp_mant  = r_mant[PIPE_STAGES-1];
  assign bus.inflight   = f_popcount(r_v);

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Time-shares one unnormalized accumulator-format adder among NREQ requesters, typically the partial-sum producers of one systolic-array column.
- Selects one requester per cycle by round-robin and drives the shared adder combinationally.
- Carries the sum plus a requester tag through a PIPE_STAGES-deep register pipeline.
- Returns results on a single valid/ready response port with whole-pipe backpressure.

Parameters:
- NREQ, 4, number of requesters (2..16).
- PIPE_STAGES, 2, register stages between the adder output and the response port (1..4); fixed latency.
- IDW, $clog2(NREQ), requester tag width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_in1  in  NREQ x $bits(accNormalSigned_t)  first operand, per requester.
- req_in2  in  NREQ x $bits(accNormalSigned_t)  second operand, per requester.
- add_in1  out  $bits(accNormalSigned_t)  to shared adder in1.
- add_in2  out  $bits(accNormalSigned_t)  to shared adder in2.
- add_sumExp  in  $bits(exponent_t)  from shared adder.
- add_sumMant  in  $bits(accMantNormalSigned_t)+1  from shared adder; signed.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  IDW  requester that issued the result.
- resp_exp  out  $bits(exponent_t)  sum exponent.
- resp_mant  out  $bits(accMantNormalSigned_t)+1  unnormalized signed sum mantissa.
- inflight  out  $clog2(PIPE_STAGES+1)+1  number of valid pipeline stages.

Behaviour:
- Reset (async, rst_n=0):
  - All stage valid bits = 0; resp_valid=0, inflight=0.
  - resp_id/resp_exp/resp_mant = 0; rr pointer = NREQ-1, so requester 0 has first priority.
- Advance: adv = !v[PIPE_STAGES-1] || resp_ready. The pipe is a global stall, with no bubble squeezing.
- Grant:
  - Combinational round-robin over req_valid.
  - Search starts at (ptr+1) mod NREQ and wraps; first valid requester wins (idx g).
  - No valid requester: no grant.
- req_ready[g] = adv; all other bits are 0. No combinational dependency of req_ready on req_valid[g] beyond grant selection.
- Accept: req_valid[g] && adv.
  - Stage 0 captures {g, add_sumExp, add_sumMant}; v[0]=1.
  - ptr <= g. ptr is unchanged when no request is accepted.
- add_in1/add_in2 = req_in1[g]/req_in2[g] when a grant exists, else 0. The adder is purely combinational and is sampled the same cycle.
- Stages: on adv, stage k+1 <= stage k and v[0] <= accept. When !adv, all stages and the pointer hold.
- Latency:
  - Request accepted on edge t gives resp_valid on edge t+PIPE_STAGES-1, i.e. visible PIPE_STAGES cycles after request presentation.
  - Throughput is one result per cycle while resp_ready=1.
- Response: resp_* = last stage; resp_valid = v[PIPE_STAGES-1]. Held stable while resp_valid && !resp_ready.
- inflight = popcount(v); updated every cycle.
- Fairness: a requester holding req_valid is granted within NREQ accepted transactions.
- Simultaneous events:
  - Response drain and new accept occur in the same cycle.
  - Requests arriving while the pipe is stalled see req_ready=0 and must hold their operands.
- Reset mid-operation clears all in-flight results with no response emitted; the pointer returns to NREQ-1.
- Arithmetic is done entirely by the shared adder; the arbiter never modifies exp/mant widths or values.

Test Plan:
- Single request: requester 2, in1={Exp=5,Mant=16}, in2={Exp=3,Mant=8}, resp_ready=1 -> after PIPE_STAGES cycles resp_valid=1, resp_id=2, resp_exp=5, resp_mant=18.
- Signed sum: in1={Exp=4,Mant=-8}, in2={Exp=4,Mant=4} -> resp_mant=-4, resp_exp=4.
- Round-robin: all 4 req_valid held high, resp_ready=1 -> accepted order 0,1,2,3,0,1; inflight saturates at PIPE_STAGES.
- Backpressure: fill pipe, drop resp_ready for 5 cycles -> req_ready=0 throughout, resp_* stable, inflight=PIPE_STAGES; on release, results drain in order with no loss or duplication.
- Reset mid-flight: 2 results in flight, assert rst_n=0 -> resp_valid=0 and inflight=0 immediately; after release the first grant goes to requester 0.
- Pointer hold: only requester 3 valid, then requesters 0 and 3 valid -> grant order 3, 0, 3.
